// File: rtl/rgb_pkg.sv
// Shared widths, constants and the hue phase encoding for the RGB hue sequencer.
package rgb_pkg;

  localparam int               PWM_W      = 8;
  localparam logic [PWM_W-1:0] DUTY_MAX   = 8'd255;
  localparam int               NUM_PHASES = 6;

  typedef enum logic [2:0] {
    PH_RG_UP = 3'd0,
    PH_R_DN  = 3'd1,
    PH_GB_UP = 3'd2,
    PH_G_DN  = 3'd3,
    PH_BR_UP = 3'd4,
    PH_B_DN  = 3'd5
  } hue_phase_e;

  function automatic hue_phase_e next_phase(input hue_phase_e p);
    case (p)
      PH_RG_UP: next_phase = PH_R_DN;
      PH_R_DN:  next_phase = PH_GB_UP;
      PH_GB_UP: next_phase = PH_G_DN;
      PH_G_DN:  next_phase = PH_BR_UP;
      PH_BR_UP: next_phase = PH_B_DN;
      PH_B_DN:  next_phase = PH_RG_UP;
      default:  next_phase = PH_RG_UP;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: shadow duty register loaded at PWM wrap, plus a registered
// comparator that produces the pad level.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter logic             ACTIVE_LOW = 1'b1,
  parameter logic [PWM_W-1:0] RESET_DUTY = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             load,
  input  logic [PWM_W-1:0] duty_in,
  output logic [PWM_W-1:0] duty,
  output logic             pin
);

  logic [PWM_W-1:0] r_duty;
  logic             r_pin;

  // Shadow duty and pad level; comparing against the old duty on the load
  // edge is harmless because pwm_cnt is 255 there and never below a duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty <= RESET_DUTY;
      r_pin  <= ACTIVE_LOW;
    end else begin
      if (load) begin
        r_duty <= duty_in;
      end
      r_pin <= (pwm_cnt < r_duty) ^ ACTIVE_LOW;
    end
  end

  assign duty = r_duty;
  assign pin  = r_pin;

endmodule

// File: rtl/hue_sequencer.sv
// Walks the RGB LED around the hue wheel: prescaled ramp/phase state, duty
// mapping, shared PWM counter and three PWM channels.
module hue_sequencer
  import rgb_pkg::*;
#(
  parameter int STEP_CYCLES = 7812,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [PWM_W-1:0] duty_r,
  output logic [PWM_W-1:0] duty_g,
  output logic [PWM_W-1:0] duty_b,
  output logic [2:0]       phase,
  output logic             step_tick,
  output logic             rgb_r,
  output logic             rgb_g,
  output logic             rgb_b
);

  localparam int             PRE_W   = $clog2(STEP_CYCLES);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_CYCLES - 1);
  localparam logic           AL_BIT  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [PRE_W-1:0] r_pre;
  logic [PWM_W-1:0] r_ramp;
  logic             r_step_tick;
  hue_phase_e       r_phase;
  hue_phase_e       w_phase_nxt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_step;
  logic             w_load;
  logic [PWM_W-1:0] w_tgt_r;
  logic [PWM_W-1:0] w_tgt_g;
  logic [PWM_W-1:0] w_tgt_b;

  assign w_step = enable && (r_pre == PRE_MAX);
  assign w_load = (r_pwm_cnt == DUTY_MAX);

  // Prescaler, ramp and the registered step pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre       <= '0;
      r_ramp      <= 8'd0;
      r_step_tick <= 1'b0;
    end else begin
      r_step_tick <= w_step;
      if (w_step) begin
        r_pre  <= '0;
        r_ramp <= r_ramp + 8'd1;
      end else if (enable) begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_RG_UP;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Phase next-state: advance when a step wraps the ramp.
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_step && (r_ramp == DUTY_MAX)) begin
      w_phase_nxt = next_phase(r_phase);
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // Target duties from phase and ramp.
  always_comb begin
    w_tgt_r = 8'd0;
    w_tgt_g = 8'd0;
    w_tgt_b = 8'd0;
    case (r_phase)
      PH_RG_UP: begin w_tgt_r = DUTY_MAX;          w_tgt_g = r_ramp;            w_tgt_b = 8'd0;              end
      PH_R_DN:  begin w_tgt_r = DUTY_MAX - r_ramp; w_tgt_g = DUTY_MAX;          w_tgt_b = 8'd0;              end
      PH_GB_UP: begin w_tgt_r = 8'd0;              w_tgt_g = DUTY_MAX;          w_tgt_b = r_ramp;            end
      PH_G_DN:  begin w_tgt_r = 8'd0;              w_tgt_g = DUTY_MAX - r_ramp; w_tgt_b = DUTY_MAX;          end
      PH_BR_UP: begin w_tgt_r = r_ramp;            w_tgt_g = 8'd0;              w_tgt_b = DUTY_MAX;          end
      PH_B_DN:  begin w_tgt_r = DUTY_MAX;          w_tgt_g = 8'd0;              w_tgt_b = DUTY_MAX - r_ramp; end
      default:  begin w_tgt_r = DUTY_MAX;          w_tgt_g = 8'd0;              w_tgt_b = 8'd0;              end
    endcase
  end

  // Free-running PWM counter, independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  pwm_channel #(.ACTIVE_LOW(AL_BIT), .RESET_DUTY(DUTY_MAX)) u_ch_r (
    .clk(clk), .reset(reset), .pwm_cnt(r_pwm_cnt), .load(w_load),
    .duty_in(w_tgt_r), .duty(duty_r), .pin(rgb_r)
  );

  pwm_channel #(.ACTIVE_LOW(AL_BIT), .RESET_DUTY(8'd0)) u_ch_g (
    .clk(clk), .reset(reset), .pwm_cnt(r_pwm_cnt), .load(w_load),
    .duty_in(w_tgt_g), .duty(duty_g), .pin(rgb_g)
  );

  pwm_channel #(.ACTIVE_LOW(AL_BIT), .RESET_DUTY(8'd0)) u_ch_b (
    .clk(clk), .reset(reset), .pwm_cnt(r_pwm_cnt), .load(w_load),
    .duty_in(w_tgt_b), .duty(duty_b), .pin(rgb_b)
  );

  assign phase     = r_phase;
  assign step_tick = r_step_tick;

endmodule

// File: tb/tb_hue_sequencer.sv
// Randomized-enable bench for hue_sequencer with a cycle-count based reference
// model and a few hand-computed anchor values.
module tb_hue_sequencer;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [2:0] phase;
  logic       step_tick;
  logic       rgb_r, rgb_g, rgb_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: enabled cycles and total cycles since reset determine everything.
  int         m_en;
  int         m_cyc;
  logic [7:0] m_duty [3];
  logic       m_pin  [3];
  logic       m_tick;

  hue_sequencer #(.STEP_CYCLES(SC), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .phase(phase), .step_tick(step_tick),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
  );

  always #5 clk = ~clk;

  // Red's level over the wheel; green and blue are the same curve shifted.
  function automatic int red_of(int p, int r);
    case (p)
      0, 5:    return 255;
      1:       return 255 - r;
      4:       return r;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] tgt(int ph, int rp, int ch);
    int p;
    p = (ch == 0) ? ph : (ch == 1) ? (ph + 4) % 6 : (ph + 2) % 6;
    return 8'(red_of(p, rp));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    int steps, rp, ph, pw;
    if (reset) begin
      m_en      <= 0;
      m_cyc     <= 0;
      m_tick    <= 1'b0;
      m_duty[0] <= 8'd255;
      m_duty[1] <= 8'd0;
      m_duty[2] <= 8'd0;
      for (int i = 0; i < 3; i++) m_pin[i] <= 1'b0;
    end else begin
      steps = m_en / SC;
      rp    = steps % 256;
      ph    = (steps / 256) % 6;
      pw    = m_cyc % 256;
      for (int i = 0; i < 3; i++) begin
        m_pin[i] <= (pw < int'(m_duty[i]));
        if (pw == 255) m_duty[i] <= tgt(ph, rp, i);
      end
      m_tick <= enable && ((m_en % SC) == SC - 1);
      if (enable) m_en <= m_en + 1;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("duty_r", duty_r, m_duty[0]);
      check("duty_g", duty_g, m_duty[1]);
      check("duty_b", duty_b, m_duty[2]);
      check("phase", phase, ((m_en / SC) / 256) % 6);
      check("step_tick", step_tick, m_tick);
      check("rgb_r", rgb_r, m_pin[0]);
      check("rgb_g", rgb_g, m_pin[1]);
      check("rgb_b", rgb_b, m_pin[2]);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty_r"}, duty_r, 255);
    check({tag, "_duty_g"}, duty_g, 0);
    check({tag, "_duty_b"}, duty_b, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_tick"}, step_tick, 0);
    check({tag, "_rgb"}, {rgb_r, rgb_g, rgb_b}, 0);
  endtask

  initial begin
    int ticks, cr, cg, cb, toggles, k, guard;
    logic prev_r;

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    enable = 1'b1;
    reset  = 1'b0;
    chk_on = 1'b1;

    // First 1024 cycles: tick count and pin duty counts in PWM period 2.
    ticks = 0; cr = 0; cg = 0; cb = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_tick) ticks++;
      if (i >= 257 && i <= 512) begin
        cr += int'(rgb_r);
        cg += int'(rgb_g);
        cb += int'(rgb_b);
      end
    end
    check("ticks_1024", ticks, 256);
    check("phase_1024", phase, 1);
    check("duty_r_1024", duty_r, 255);
    check("duty_g_1024", duty_g, 255);
    check("duty_b_1024", duty_b, 0);
    check("on_cnt_r_255", cr, 255);
    check("on_cnt_g_63", cg, 63);
    check("on_cnt_b_0", cb, 0);

    cycles(2816 - 1024);
    check("phase_2816", phase, 2);
    check("duty_r_2816", duty_r, 0);
    check("duty_g_2816", duty_g, 255);
    check("duty_b_2816", duty_b, 191);

    cycles(6144 - 2816);
    check("phase_wrap_6144", phase, 0);

    // Freeze mid-phase: no ticks, PWM still running.
    cycles(300);
    enable  = 1'b0;
    ticks   = 0;
    toggles = 0;
    prev_r  = rgb_r;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_tick) ticks++;
      if (rgb_r != prev_r) toggles++;
      prev_r = rgb_r;
    end
    check("freeze_ticks", ticks, 0);
    check("freeze_pwm_toggles", int'(toggles > 0), 1);
    enable = 1'b1;

    // Drop enable exactly when the prescaler sits at its last count.
    for (int n = 0; n < 6; n++) begin
      guard = 0;
      while (((m_en % SC) != SC - 1) && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("prewrap_wait", int'(guard < 20), 1);
      enable = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check("tick_after_resume", step_tick, 1);
    end

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_tick && k == 0) k = i;
    end
    check("first_tick_after_reset", k, 4);

    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 4) != 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hue_sequencer.md
# hue_sequencer

- Sequences the RGB LED PWM datapath around the full hue wheel.
- A step prescaler advances an 8-bit ramp through six hue phases. The phase and ramp set three duty values, and three PWM comparators turn those duties into the LED pin levels.
- Sits directly under `top`, between `clk` and the `RGB_R`/`RGB_G`/`RGB_B` pads.
- With default parameters one full hue revolution takes about 1 s at 12 MHz.

## Interface
Parameters:
- `STEP_CYCLES`, 7812: clocks per ramp step (12 MHz / (6·256) ≈ 1 s revolution); legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 means the outputs are inverted for the active-low LED pads.

Ports:
- `clk` input 1: system clock, 12 MHz.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: 1 lets the hue advance; 0 freezes the hue while PWM keeps running.
- `duty_r`, `duty_g`, `duty_b` output 8 each: currently applied (shadow) duty values.
- `phase` output 3: current hue phase, 0–5.
- `step_tick` output 1: one-cycle pulse on each ramp step.
- `rgb_r`, `rgb_g`, `rgb_b` output 1 each: PWM pin levels.

## Operation
- **Prescaler** `pre`:
  - Counts 0..STEP_CYCLES-1 only while `enable` is 1; holds its value while `enable` is 0.
  - `step_tick` is 1 when `enable` is 1 and `pre` equals STEP_CYCLES-1; `pre` wraps to 0 on that cycle.
- **Ramp** `ramp` (8 bit): increments on `step_tick`.
  - When a step occurs with `ramp` at 255, `ramp` wraps to 0 and `phase` advances; phase 5 wraps to 0.
- **Target duties** (combinational from `phase` and `ramp`):
  - phase 0: R = 255, G = ramp, B = 0
  - phase 1: R = 255−ramp, G = 255, B = 0
  - phase 2: R = 0, G = 255, B = ramp
  - phase 3: R = 0, G = 255−ramp, B = 255
  - phase 4: R = ramp, G = 0, B = 255
  - phase 5: R = 255, G = 0, B = 255−ramp
- **PWM counter** `pwm_cnt` (8 bit): free-running 0..255, wraps to 0, and ignores `enable`.
- **Shadow duties**: all three load the target duties together, only on the cycle where `pwm_cnt` is 255. A duty value therefore never changes in the middle of a PWM period.
- **Pin level**: `rgb_x` is registered as (`pwm_cnt` < `duty_x`) XOR `ACTIVE_LOW`.
  - Duty 0 gives a pin that is never on.
  - Duty 255 gives 255 on-cycles out of 256.
- **Simultaneous events**:
  - A step and a shadow load in the same cycle: the shadow takes the pre-step target. The post-step value loads at the next wrap.
  - `enable` falling on the cycle `pre` reaches STEP_CYCLES-1: no tick; `pre` holds at STEP_CYCLES-1. The tick fires on the first cycle `enable` is 1 again.

## Timing
- **Reset values** (asynchronous):
  - `pre` = 0, `ramp` = 0, `phase` = 0, `pwm_cnt` = 0, `step_tick` = 0.
  - `duty_r` = 255, `duty_g` = 0, `duty_b` = 0, matching the phase-0 / ramp-0 target.
  - `rgb_r`, `rgb_g`, `rgb_b` = off level, which equals `ACTIVE_LOW`.
- **Reset mid-operation**: everything returns to the reset values immediately. The first step after release comes STEP_CYCLES clocks later.
- **Latency**:
  - `step_tick` and the `ramp`/`phase` update occur in the same edge.
  - The shadow duty updates at the next `pwm_cnt`==255 edge, 1–256 cycles after the step.
  - The pin reflects the comparison one cycle after `pwm_cnt`.
- **Periods**:
  - Revolution = 6·256·STEP_CYCLES cycles of enabled time.
  - PWM period = 256 cycles.

## Structure
- **Package `rgb_pkg`**: `PWM_W` = 8, `DUTY_MAX` = 255, `NUM_PHASES` = 6, and the enum `hue_phase_e` (PH_RG_UP, PH_R_DN, PH_GB_UP, PH_G_DN, PH_BR_UP, PH_B_DN).
- **Sub-module `pwm_channel`**:
  - Ports: `clk`, `reset`, `pwm_cnt`, `load`, `duty_in`, `duty`, `pin`.
  - Holds the shadow duty register and the registered comparator.
  - Instantiated three times.
- **Parent**: holds the prescaler, the ramp/phase state, the duty mapping and the shared PWM counter.

## Test plan
All tests use STEP_CYCLES = 4 and ACTIVE_LOW = 0.
1. Reset, then hold `enable` = 1 for 1024 cycles → `step_tick` pulses every 4 cycles (256 pulses). Then `phase` = 1, `ramp` = 0.
2. Run a full revolution (6144 cycles) → `phase` steps through 0..5 and wraps to 0. At each phase boundary the targets match the table, e.g. at phase 2 with ramp 128: R = 0, G = 255, B = 128.
3. With `duty_g` = 64 latched, count `rgb_g` high cycles over one PWM period → exactly 64 of 256. Duty 0 gives 0; duty 255 gives 255.
4. Hold `enable` = 0 for 500 cycles mid-phase → `ramp`, `phase` and `pre` are frozen and there is no `step_tick`. `rgb_*` keeps toggling at the latched duty.
5. Change the target mid-PWM-period → `duty_*` changes only on the edge where `pwm_cnt` is 255. No pin glitch occurs within the period.
6. Assert `reset` asynchronously mid-phase (no clock edge) → outputs take the reset values immediately, `rgb_*` = 0. After release, the first `step_tick` comes on cycle 4.
